// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding, digit
// width and per-digit moduli for the M:SS.T display chain.
package stopwatch_pkg;

  localparam int BCD_W    = 4;

  localparam int DIG0_MOD = 10;  // tenths of seconds
  localparam int DIG1_MOD = 10;  // seconds units
  localparam int DIG2_MOD = 6;   // seconds tens
  localparam int DIG3_MOD = 10;  // minutes

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One modulo-MOD BCD digit. Counts up on inc, wraps to 0 after MOD-1 and
// raises carry in that same cycle so the next digit advances together.
// clr has priority over inc.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] TOP = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // next digit value: clear, wrap at the top, or step by one
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == TOP) ? '0 : q_q + 1'b1;
    end
  end

  // digit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == TOP);

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch M:SS.T driven by a 0.1 s tick strobe.
// Holds the IDLE/RUN/PAUSE control FSM, the overflow/saturation logic and
// the four chained BCD digits.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze register on the
// display outputs). Without it the lap input is ignored.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter bit WRAP     = 1'b1,
  parameter int ID_WIDTH = BCD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                go,
  input  logic                stop,
  input  logic                clr,
  input  logic                lap,
  output logic [ID_WIDTH-1:0] d0,
  output logic [ID_WIDTH-1:0] d1,
  output logic [ID_WIDTH-1:0] d2,
  output logic [ID_WIDTH-1:0] d3,
  output logic                running,
  output logic                ovf
);

  sw_state_e state_q, state_d;
  logic      running_q, running_d;
  logic      ovf_q, ovf_d;

  logic [BCD_W-1:0] l0, l1, l2, l3;
  logic             c0, c1, c2, c3;
  logic             at_max;
  logic             cnt_evt;
  logic             ovf_evt;
  logic             hold;
  logic             inc0;
  logic [4*BCD_W-1:0] live;
  logic [4*BCD_W-1:0] disp;

  // 9:59.9 is the last representable time
  assign at_max  = (l3 == BCD_W'(DIG3_MOD - 1)) && (l2 == BCD_W'(DIG2_MOD - 1)) &&
                   (l1 == BCD_W'(DIG1_MOD - 1)) && (l0 == BCD_W'(DIG0_MOD - 1));
  // a tick coinciding with stop or clr is dropped
  assign cnt_evt = (state_q == RUN) & tick & ~stop & ~clr;
  assign ovf_evt = cnt_evt & at_max;
  // saturating build freezes the digits at 9:59.9
  assign hold    = ovf_evt & ~WRAP;
  assign inc0    = cnt_evt & ~hold;

  bcd_digit #(.MOD(DIG0_MOD)) u_dig0 (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc0), .q(l0), .carry(c0)
  );
  bcd_digit #(.MOD(DIG1_MOD)) u_dig1 (
    .clk(clk), .rst(rst), .clr(clr), .inc(c0),   .q(l1), .carry(c1)
  );
  bcd_digit #(.MOD(DIG2_MOD)) u_dig2 (
    .clk(clk), .rst(rst), .clr(clr), .inc(c1),   .q(l2), .carry(c2)
  );
  bcd_digit #(.MOD(DIG3_MOD)) u_dig3 (
    .clk(clk), .rst(rst), .clr(clr), .inc(c2),   .q(l3), .carry(c3)
  );

  // minute carry-out has no consumer; wrap is handled by the digit itself
  logic unused_c3;
  assign unused_c3 = c3;

  assign live = {l3, l2, l1, l0};

  // control FSM next state with clr > stop > go priority; the first
  // saturation in the non-wrapping build parks the watch in PAUSE, while a
  // resumed run after overflow stays in RUN with digits held
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (hold && !ovf_q) begin
      state_d = PAUSE;
    end else if (go) begin
      state_d = RUN;
    end
  end

  // sticky overflow flag and registered running indicator
  always_comb begin
    ovf_d     = ovf_q;
    running_d = (state_d == RUN);
    if (clr) begin
      ovf_d = 1'b0;
    end else if (ovf_evt) begin
      ovf_d = 1'b1;
    end
  end

  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic               frz_q, frz_d;
  logic [4*BCD_W-1:0] lap_q, lap_d;

  // lap toggles between snapshotting the live time and releasing the freeze
  always_comb begin
    frz_d = frz_q;
    lap_d = lap_q;
    if (clr) begin
      frz_d = 1'b0;
      lap_d = '0;
    end else if (lap) begin
      if (!frz_q) begin
        lap_d = live;
        frz_d = 1'b1;
      end else begin
        frz_d = 1'b0;
      end
    end
  end

  // lap snapshot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz_q <= 1'b0;
      lap_q <= '0;
    end else begin
      frz_q <= frz_d;
      lap_q <= lap_d;
    end
  end

  assign disp = frz_q ? lap_q : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = live;
`endif

  assign d0      = disp[0*BCD_W +: BCD_W];
  assign d1      = disp[1*BCD_W +: BCD_W];
  assign d2      = disp[2*BCD_W +: BCD_W];
  assign d3      = disp[3*BCD_W +: BCD_W];
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a wrapping and a saturating instance
// share one stimulus stream; a time-in-tenths reference model predicts the
// display, and a monitor compares one cycle after each edge.
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int MAX_T = 5999;

  logic clk = 1'b0;
  logic rst, tick, go, stop, clr, lap;
  logic [3:0] w1_d0, w1_d1, w1_d2, w1_d3, w0_d0, w0_d1, w0_d2, w0_d3;
  logic w1_run, w1_ovf, w0_run, w0_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [17:0] e1;
    logic [17:0] e0;
  } exp_t;
  exp_t sb[$];

  // model state, index 1 = wrapping, 0 = saturating
  int t_m[2];
  int st_m[2];   // 0 idle, 1 run, 2 pause
  bit ovf_m[2];
  bit frz_m[2];
  int lapt_m[2];

  always #5 clk = ~clk;

  stopwatch_bcd #(.WRAP(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .tick(tick), .go(go), .stop(stop), .clr(clr), .lap(lap),
    .d0(w1_d0), .d1(w1_d1), .d2(w1_d2), .d3(w1_d3), .running(w1_run), .ovf(w1_ovf)
  );

  stopwatch_bcd #(.WRAP(1'b0)) dut_w0 (
    .clk(clk), .rst(rst), .tick(tick), .go(go), .stop(stop), .clr(clr), .lap(lap),
    .d0(w0_d0), .d1(w0_d1), .d2(w0_d2), .d3(w0_d3), .running(w0_run), .ovf(w0_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int t);
    int m, rem;
    m   = t / 600;
    rem = t % 600;
    return {4'(m), 4'(rem / 100), 4'((rem / 10) % 10), 4'(rem % 10)};
  endfunction

  function automatic logic [17:0] model_out(input int i);
    int shown;
    shown = (LAP_EN && frz_m[i]) ? lapt_m[i] : t_m[i];
    return {bcd(shown), st_m[i] == 1, ovf_m[i]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      t_m[i] = 0; st_m[i] = 0; ovf_m[i] = 0; frz_m[i] = 0; lapt_m[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i, input bit w, input bit tk, input bit g,
                                     input bit s, input bit c, input bit l);
    int t0;
    bit sat_pause;
    t0 = t_m[i];
    sat_pause = 1'b0;
    if (c) begin
      t_m[i] = 0; st_m[i] = 0; ovf_m[i] = 0; frz_m[i] = 0; lapt_m[i] = 0;
    end else begin
      if (st_m[i] == 1 && tk && !s) begin
        if (t0 == MAX_T) begin
          if (!w && !ovf_m[i]) sat_pause = 1'b1;
          if (w) t_m[i] = 0;
          ovf_m[i] = 1'b1;
        end else begin
          t_m[i] = t0 + 1;
        end
      end
      if (s) begin
        if (st_m[i] == 1) st_m[i] = 2;
      end else if (sat_pause) begin
        st_m[i] = 2;
      end else if (g) begin
        st_m[i] = 1;
      end
      if (l) begin
        if (!frz_m[i]) begin
          lapt_m[i] = t0;
          frz_m[i]  = 1'b1;
        end else begin
          frz_m[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic drive(input bit tk, input bit g, input bit s, input bit c, input bit l);
    exp_t e;
    tick = tk; go = g; stop = s; clr = c; lap = l;
    model_step(1, 1'b1, tk, g, s, c, l);
    model_step(0, 1'b0, tk, g, s, c, l);
    e.e1 = model_out(1);
    e.e0 = model_out(0);
    sb.push_back(e);
  endtask

  task automatic step(input bit tk, input bit g, input bit s, input bit c, input bit l);
    @(negedge clk);
    drive(tk, g, s, c, l);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
  endtask

  // assert reset between edges; outputs must drop before the next edge
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_w1", {w1_d3, w1_d2, w1_d1, w1_d0, w1_run, w1_ovf}, 18'd0);
    chk("async_rst_w0", {w0_d3, w0_d2, w0_d1, w0_d0, w0_run, w0_ovf}, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
  endtask

  // monitor: compare each edge's result against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_wrap", {w1_d3, w1_d2, w1_d1, w1_d0, w1_run, w1_ovf}, e.e1);
        chk("out_sat",  {w0_d3, w0_d2, w0_d1, w0_d0, w0_run, w0_ovf}, e.e0);
      end
    end
  end

  initial begin
    rst = 1'b0; tick = 0; go = 0; stop = 0; clr = 0; lap = 0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_w1", {w1_d3, w1_d2, w1_d1, w1_d0, w1_run, w1_ovf}, 18'd0);
    chk("reset_w0", {w0_d3, w0_d2, w0_d1, w0_d0, w0_run, w0_ovf}, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    // go, 25 ticks with gaps, then stop+tick is dropped
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      step(1, 0, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0);
    end
    step(1, 0, 1, 0, 0);
    ticks(3);
    step(1, 1, 1, 0, 0);

    // run to 1:23.4 (crosses 0:59.9 -> 1:00.0), then async reset
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(834);
    async_reset();

    // 3:10.2 then clr+tick+go together, then go+tick from IDLE
    step(0, 1, 0, 0, 0);
    ticks(1902);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    ticks(4);

    // full range to overflow: wrap keeps running, saturate pauses
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(6000);
    ticks(3);
    step(0, 1, 0, 0, 0);
    ticks(3);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);

    // lap freeze at 0:05.0 with counting underneath
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(50);
    step(0, 0, 0, 0, 1);
    ticks(12);
    step(0, 0, 0, 0, 1);
    ticks(2);

    // randomized control mix
    for (int n = 0; n < 20000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 1023) == 0,
           $urandom_range(0, 63) == 0);
      if (n == 7000 || n == 15000) async_reset();
    end

    step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
